// File: rtl/antares_fetch_controller_pkg.sv
// Shared types and constants for the Antares instruction-fetch controller.
// RESET_VECTOR_DEFAULT must track the PC register's reset base.
package antares_fetch_controller_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } fc_state_e;

  localparam logic [31:0] PC_INC               = 32'h4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/antares_fetch_controller_if.sv
// Bundle of PC-register, instruction-memory and redirect signals around the fetch controller.
// The master modport is the controller's view; slave is the surrounding pipeline.
interface antares_fetch_controller_if;
  logic [31:0] if_pc;
  logic [31:0] if_new_pc;
  logic        if_stall;
  logic        imem_req;
  logic        imem_ready;
  logic        id_stall;
  logic        br_req;
  logic [31:0] br_target;
  logic        exc_req;
  logic [31:0] exc_vector;
  logic        if_valid;
  logic        if_kill;
  logic        redirect_pending;

  modport master (
    input  if_pc, imem_ready, id_stall, br_req, br_target, exc_req, exc_vector,
    output if_new_pc, if_stall, imem_req, if_valid, if_kill, redirect_pending
  );

  modport slave (
    output if_pc, imem_ready, id_stall, br_req, br_target, exc_req, exc_vector,
    input  if_new_pc, if_stall, imem_req, if_valid, if_kill, redirect_pending
  );
endinterface

// File: rtl/antares_redirect_buffer.sv
// Holds a branch/exception redirect that arrived while no instruction was advancing,
// and merges it with same-cycle redirects into the next-PC choice.
module antares_redirect_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance_i,
  input  logic        br_req_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_req_i,
  input  logic [31:0] exc_vector_i,
  output logic        pend_exc_o,
  output logic        pend_br_o,
  output logic        redir_valid_o,
  output logic [31:0] redir_target_o,
  output logic        kill_o
);
  logic        pend_exc_q, pend_exc_d;
  logic        pend_br_q, pend_br_d;
  logic [31:0] pend_target_q, pend_target_d;

  always_comb begin
    pend_exc_d    = pend_exc_q;
    pend_br_d     = pend_br_q;
    pend_target_d = pend_target_q;
    // Any advance consumes whatever was pending; a losing branch is simply dropped.
    if (advance_i) begin
      pend_exc_d = 1'b0;
      pend_br_d  = 1'b0;
    end else if (exc_req_i) begin
      pend_exc_d    = 1'b1;
      pend_br_d     = 1'b0;
      pend_target_d = exc_vector_i;
    end else if (br_req_i && !pend_exc_q) begin
      pend_br_d     = 1'b1;
      pend_target_d = br_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_exc_q <= 1'b0;
      pend_br_q  <= 1'b0;
    end else begin
      pend_exc_q <= pend_exc_d;
      pend_br_q  <= pend_br_d;
    end
  end

  // Target is qualified by the flags, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_target_q <= pend_target_d;
  end

  always_comb begin
    redir_target_o = pend_target_q;
    if (exc_req_i)       redir_target_o = exc_vector_i;
    else if (pend_exc_q) redir_target_o = pend_target_q;
    else if (br_req_i)   redir_target_o = br_target_i;
  end

  assign pend_exc_o    = pend_exc_q;
  assign pend_br_o     = pend_br_q;
  assign kill_o        = exc_req_i | pend_exc_q;
  assign redir_valid_o = exc_req_i | pend_exc_q | br_req_i | pend_br_q;

endmodule

// File: rtl/antares_fetch_controller.sv
// IF-stage sequencer: boot delay, instruction-memory handshake, back-pressure hold,
// and next-PC selection with buffered branch/exception redirects.
module antares_fetch_controller
  import antares_fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned BOOT_DELAY   = 2
) (
  input logic                        clk,
  input logic                        rst,
  antares_fetch_controller_if.master bus
);
  localparam logic [3:0] BOOT_CNT = 4'(BOOT_DELAY);

  fc_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        advance;
  logic        req;
  logic        kill;
  logic        redir_valid;
  logic        pend_exc;
  logic        pend_br;
  logic [31:0] redir_target;
  logic [31:0] new_pc;

  antares_redirect_buffer u_redirect_buffer (
    .clk            (clk),
    .rst            (rst),
    .advance_i      (advance),
    .br_req_i       (bus.br_req),
    .br_target_i    (bus.br_target),
    .exc_req_i      (bus.exc_req),
    .exc_vector_i   (bus.exc_vector),
    .pend_exc_o     (pend_exc),
    .pend_br_o      (pend_br),
    .redir_valid_o  (redir_valid),
    .redir_target_o (redir_target),
    .kill_o         (kill)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    req     = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        if (cnt_q == 4'd0) state_d = ST_FETCH;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_FETCH: begin
        req = 1'b1;
        if (bus.imem_ready) begin
          if (bus.id_stall) state_d = ST_HOLD;
          else              advance = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!bus.id_stall) begin
          advance = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
        cnt_d   = BOOT_CNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      cnt_q   <= BOOT_CNT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outside an advance the PC register is stalled, so new_pc only matters for visibility.
  always_comb begin
    new_pc = bus.if_pc;
    if (state_q != ST_FETCH && state_q != ST_HOLD) new_pc = RESET_VECTOR;
    else if (advance && redir_valid)               new_pc = redir_target;
    else if (advance)                              new_pc = bus.if_pc + PC_INC;
  end

  assign bus.if_new_pc        = new_pc;
  assign bus.imem_req         = req;
  assign bus.if_stall         = ~advance;
  assign bus.if_valid         = advance & ~kill;
  assign bus.if_kill          = advance & kill;
  assign bus.redirect_pending = pend_exc | pend_br;

endmodule

// File: tb/tb_antares_fetch_controller.sv
// Randomized scoreboard bench for antares_fetch_controller against a cycle-level reference model.
module tb_antares_fetch_controller;
  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam int          BD = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic        kill;
  } deliv_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  antares_fetch_controller_if bus ();

  antares_fetch_controller #(.RESET_VECTOR(RV), .BOOT_DELAY(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // PC register in the environment
  always @(posedge clk or negedge rst) begin
    if (!rst)              bus.if_pc <= RV;
    else if (!bus.if_stall) bus.if_pc <= bus.if_new_pc;
  end

  int n_tests = 0;
  int n_fail  = 0;

  deliv_t q[$];
  bit     exp_live = 1'b0;
  bit     e_req, e_stall, e_pend, e_boot;

  // Reference model state: boot countdown, whether fetched data is held, one pending redirect.
  bit          m_boot;
  int          m_boot_left;
  bit          m_held;
  int          m_pk;      // 0 none, 1 branch, 2 exception
  logic [31:0] m_pt;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_boot      = 1'b1;
    m_boot_left = BD;
    m_held      = 1'b0;
    m_pk        = 0;
    m_pt        = '0;
    m_pc        = RV;
    q.delete();
  endtask

  // Entered and left at a falling edge; drives one cycle and predicts its outcome.
  task automatic cycle(input bit rdy, input bit stl, input bit br, input logic [31:0] bt,
                       input bit ex, input logic [31:0] ev);
    bit          deliver;
    logic [31:0] npc;
    bit          k;
    bus.imem_ready = rdy;
    bus.id_stall   = stl;
    bus.br_req     = br;
    bus.br_target  = bt;
    bus.exc_req    = ex;
    bus.exc_vector = ev;
    deliver = 1'b0;
    npc     = m_pc;
    k       = 1'b0;
    e_boot  = m_boot;
    if (m_boot) begin
      e_req   = 1'b0;
      e_stall = 1'b1;
    end else begin
      e_req   = !m_held;
      deliver = (m_held || rdy) && !stl;
      e_stall = !deliver;
    end
    e_pend = (m_pk != 0);
    if (deliver) begin
      if (ex)             begin npc = ev;   k = 1'b1; end
      else if (m_pk == 2) begin npc = m_pt; k = 1'b1; end
      else if (br)        npc = bt;
      else if (m_pk == 1) npc = m_pt;
      else                npc = m_pc + 32'd4;
      q.push_back('{pc: npc, kill: k});
    end
    exp_live = 1'b1;
    @(posedge clk);
    if (m_boot) begin
      if (m_boot_left == 0) m_boot = 1'b0;
      else                  m_boot_left--;
    end else begin
      m_held = (m_held || rdy) && stl;
    end
    if (deliver) begin
      m_pk = 0;
      m_pc = npc;
    end else if (ex) begin
      m_pk = 2;
      m_pt = ev;
    end else if (br && m_pk != 2) begin
      m_pk = 1;
      m_pt = bt;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    exp_live = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_if_stall", 32'(bus.if_stall), 32'd1);
    chk("rst_if_new_pc", bus.if_new_pc, RV);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_kill", 32'(bus.if_kill), 32'd0);
    chk("rst_redirect_pending", 32'(bus.redirect_pending), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compares control outputs every live cycle and pops the scoreboard on delivery.
  initial begin
    deliv_t d;
    forever begin
      @(negedge clk);
      #2;
      if (exp_live) begin
        chk("imem_req", 32'(bus.imem_req), 32'(e_req));
        chk("if_stall", 32'(bus.if_stall), 32'(e_stall));
        chk("redirect_pending", 32'(bus.redirect_pending), 32'(e_pend));
        if (e_boot) chk("boot_if_new_pc", bus.if_new_pc, RV);
        if (bus.if_valid || bus.if_kill) begin
          if (q.size() == 0) begin
            chk("unexpected_delivery", 32'(bus.if_valid | bus.if_kill), 32'd0);
          end else begin
            d = q.pop_front();
            chk("if_new_pc", bus.if_new_pc, d.pc);
            chk("if_valid", 32'(bus.if_valid), 32'(!d.kill));
            chk("if_kill", 32'(bus.if_kill), 32'(d.kill));
          end
        end else if (q.size() != 0) begin
          d = q.pop_front();
          chk("missing_delivery", 32'(bus.if_valid | bus.if_kill), 32'd1);
        end
      end
    end
  end

  initial begin
    bit          rdy, stl, br, ex;
    logic [31:0] bt, ev;
    bus.imem_ready = 1'b0;
    bus.id_stall   = 1'b0;
    bus.br_req     = 1'b0;
    bus.br_target  = '0;
    bus.exc_req    = 1'b0;
    bus.exc_vector = '0;
    #1;
    chk("init_imem_req", 32'(bus.imem_req), 32'd0);
    chk("init_if_stall", 32'(bus.if_stall), 32'd1);
    chk("init_if_new_pc", bus.if_new_pc, RV);
    chk("init_redirect_pending", 32'(bus.redirect_pending), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Boot then streaming fetches
    repeat (8) cycle(1, 0, 0, 0, 0, 0);
    // Memory wait states
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Branch during a waiting fetch
    cycle(0, 0, 1, 32'h8000_0100, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Pending branch superseded by an exception
    cycle(0, 0, 1, 32'h8000_0200, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h8000_0180);
    cycle(0, 0, 1, 32'h8000_0300, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Simultaneous branch and exception
    cycle(0, 0, 1, 32'h8000_0400, 1, 32'h8000_0180);
    cycle(1, 0, 0, 0, 0, 0);
    // Same-cycle branch during an advance
    cycle(1, 0, 1, 32'h8000_0500, 0, 0);
    // Back-pressure hold
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // PC wrap
    cycle(1, 0, 1, 32'hFFFF_FFF8, 0, 0);
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    // Reset mid-fetch with a pending exception
    cycle(0, 0, 0, 0, 1, 32'h8000_0180);
    cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (6) cycle(1, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      rdy = ($urandom_range(0, 9) < 6);
      stl = ($urandom_range(0, 9) < 3);
      br  = ($urandom_range(0, 9) == 0);
      ex  = ($urandom_range(0, 19) == 0);
      bt  = $urandom & 32'hFFFF_FFFC;
      ev  = $urandom & 32'hFFFF_FFFC;
      cycle(rdy, stl, br, bt, ex, ev);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    exp_live = 1'b0;
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/antares_fetch_controller.md
Name: antares_fetch_controller

Overview:
- Sequences the instruction-fetch PC register: generates if_new_pc and if_stall for it.
- Drives the instruction-memory request handshake and absorbs pipeline back-pressure.
- Buffers branch/exception redirects that arrive while a fetch is in flight, then applies them.
- Sits in the IF stage between the PC register, instruction memory and the ID/EX redirect sources.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, first PC presented after reset.
- BOOT_DELAY, 2, idle cycles after reset release before the first fetch request (range 0..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- if_pc  in  32  current PC from the PC register
- if_new_pc  out  32  next PC to the PC register
- if_stall  out  1  1 = PC register holds its value
- imem_req  out  1  fetch request, address = if_pc
- imem_ready  in  1  fetch complete this cycle
- id_stall  in  1  downstream cannot accept an instruction
- br_req  in  1  single-cycle branch/jump redirect pulse
- br_target  in  32  branch target, valid with br_req
- exc_req  in  1  single-cycle exception redirect pulse
- exc_vector  in  32  exception vector, valid with exc_req
- if_valid  out  1  fetched instruction is delivered this cycle
- if_kill  out  1  fetched instruction is squashed this cycle
- redirect_pending  out  1  a buffered redirect is waiting

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT, counter=BOOT_DELAY, pending cleared. Outputs: imem_req=0, if_stall=1, if_new_pc=RESET_VECTOR, if_valid=0, if_kill=0, redirect_pending=0.
- Mid-transaction reset: imem_req drops immediately and the in-flight fetch is abandoned.
- All outputs are combinational from the registered state, pending registers and inputs.
- BOOT: imem_req=0, if_stall=1. The 4-bit counter decrements each cycle. Move to FETCH in the cycle after the counter reads 0; with BOOT_DELAY=0, FETCH is entered on the first clock after reset release.
- FETCH: imem_req=1.
  - imem_ready=0: if_stall=1, stay.
  - imem_ready=1, id_stall=0: advance.
  - imem_ready=1, id_stall=1: go to HOLD, if_stall=1, no delivery.
- HOLD: imem_req=0, if_stall=1 while id_stall=1. When id_stall=0: advance, return to FETCH.
- Advance cycle: if_stall=0, if_valid=~kill_this, if_kill=kill_this. Next-PC priority:
  1. exc_req
  2. pending exception
  3. br_req
  4. pending branch
  5. if_pc+4 (mod 2^32; wrap from 32'hFFFF_FFFC to 0)
- Redirect arriving outside an advance cycle is captured as pending.
  - A new exception overwrites any pending branch or exception.
  - A branch never overwrites a pending exception.
  - A new branch overwrites a pending branch.
  - Pending is cleared on the advance that consumes it.
- kill_this is 1 if exc_req is asserted this cycle or an exception is pending. Branches do not kill: the instruction in fetch is the delay slot.
- exc_req and br_req in the same cycle: exception wins, branch is discarded.
- redirect_pending = pending exception OR pending branch.
- State encoding: BOOT, FETCH, HOLD (2 bits); illegal encodings go to BOOT.

Decomposition:
- Shared package/defines: state encodings, the 32'h4 PC increment, RESET_VECTOR default (same constant as the PC register's reset base).
- One natural sub-module: antares_redirect_buffer. It holds the pending target, type and priority-merge logic, and outputs pending flags plus target.

Test Plan:
- Reset release, BOOT_DELAY=2, imem_ready=1, id_stall=0 -> imem_req=0 for 3 cycles, then rises. if_new_pc sequence 32'hBFC0_0004, 32'hBFC0_0008, ...; if_valid=1 each cycle.
- imem_ready held 0 for 3 cycles at if_pc=32'hBFC0_0010 -> if_stall=1 and imem_req=1 for those cycles. On ready: if_new_pc=32'hBFC0_0014, if_stall=0.
- br_req with br_target=32'h8000_0100 during a waiting fetch -> redirect_pending=1. The next advance gives if_new_pc=32'h8000_0100, if_valid=1, if_kill=0, pending cleared.
- Pending branch, then exc_req with exc_vector=32'h8000_0180 before the advance -> advance gives if_new_pc=32'h8000_0180, if_kill=1, if_valid=0. Same result when br_req and exc_req fire in the same cycle.
- imem_ready=1 with id_stall=1 for 2 cycles -> state HOLD, imem_req=0, if_stall=1. id_stall falls -> one advance, then FETCH resumes.
- rst asserted mid-FETCH with a pending exception -> imem_req=0 immediately, redirect_pending=0, if_new_pc=RESET_VECTOR. The BOOT count restarts on release.
